// File: rtl/a_debouncer.sv
// rtl/a_debouncer.sv - synchroniser plus four-state debounce FSM for the detector input a
// Optional rise/fall pulse flops are built when A_DEBOUNCER_EDGE_EN is defined.
module a_debouncer #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  output logic a,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [SYNC_STAGES-1:0] sync;
  logic                 s;

  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], a_raw};
  end

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_LOW;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_LOW: begin
        if (s) begin
          state_d = S_WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      S_WAIT_HIGH: begin
        if (!s) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!s) begin
          state_d = S_WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      S_WAIT_LOW: begin
        if (s) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign a    = (state == S_HIGH) || (state == S_WAIT_LOW);
  assign busy = (state == S_WAIT_HIGH) || (state == S_WAIT_LOW);

`ifdef A_DEBOUNCER_EDGE_EN
  // Pulses fire on the same edge that commits the level, so they align with the first new a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= (state == S_WAIT_HIGH) && s && (cnt == CNT_LAST);
      fall <= (state == S_WAIT_LOW) && !s && (cnt == CNT_LAST);
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule
